count_lead: RTL

COUNT_LEAD -- requirements
Module: count_lead

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/count_lead_if.sv | 27 ++
 rtl/count_lead_nibble_lz.sv | 20 ++
 rtl/count_lead.sv | 120 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the count_lead block: word/count/nibble widths,
// the scan FSM state encoding and a zero-extension helper.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 6;
  localparam int NIB_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widen a leading count to a full result word.
  function automatic logic [WORD_W-1:0] zext_cnt(input logic [CNT_W-1:0] c);
    return {{(WORD_W-CNT_W){1'b0}}, c};
  endfunction

endpackage

// File: rtl/count_lead_if.sv
// Request/result bundle of the count_lead block.
// master: requester side (drives start/ones/A), slave: the counter itself.
interface count_lead_if;
  import cpu_pkg::*;

  logic              start;
  logic              ones;
  logic [WORD_W-1:0] A;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] Result;
  logic              Zero;
  logic              Carry;
  logic              Negative;
  logic              Overflow;

  modport master (
    output start, ones, A,
    input  busy, done, Result, Zero, Carry, Negative, Overflow
  );

  modport slave (
    input  start, ones, A,
    output busy, done, Result, Zero, Carry, Negative, Overflow
  );

endinterface

// File: rtl/count_lead_nibble_lz.sv
// nibble_lz: combinational leading-zero count of one 4-bit nibble.
// lz is only meaningful when nz=1 (an all-zero nibble reports lz=3).
module nibble_lz
  import cpu_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [1:0]       lz,
  output logic             nz
);

  // Priority encode from the MSB down.
  always_comb begin
    nz = |nib;
    lz = 2'd3;
    if (nib[3])      lz = 2'd0;
    else if (nib[2]) lz = 2'd1;
    else if (nib[1]) lz = 2'd2;
  end

endmodule

// File: rtl/count_lead.sv
// count_lead: multi-cycle leading-zero / leading-one counter.
// The operand is scanned one nibble per cycle from the MSB end; the scan
// stops at the first non-zero nibble, so latency depends on the data.
// Build option: define COUNT_LEAD_CLO_EN to honour the ones input (CLO by
// inverting the operand on capture). Without it the block is CLZ only and
// no inverter is built.
module count_lead
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  count_lead_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - NIB_W);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] NIB_STEP = CNT_W'(NIB_W);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] scan_q,  scan_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [CNT_W-1:0]  result_q, result_d;
  logic              zero_q,  zero_d;
  logic              carry_q, carry_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic [WORD_W-1:0] operand;
  logic [1:0]        nib_lz;
  logic              nib_nz;

  // Operand as it enters the scan register (inverted for CLO when enabled).
`ifdef COUNT_LEAD_CLO_EN
  always_comb operand = bus.ones ? ~bus.A : bus.A;
`else
  logic unused_ones;
  assign unused_ones = bus.ones;
  always_comb operand = bus.A;
`endif

  nibble_lz u_nibble_lz (
    .nib (scan_q[WORD_W-1 -: NIB_W]),
    .lz  (nib_lz),
    .nz  (nib_nz)
  );

  // Next-state, scan datapath and result/flag computation.
  always_comb begin
    state_d  = state_q;
    scan_d   = scan_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          scan_d  = operand;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (nib_nz) begin
          result_d = cnt_q + {{(CNT_W-2){1'b0}}, nib_lz};
          state_d  = DONE;
        end else if (cnt_q == LAST_CNT) begin
          // Eighth zero nibble: no terminating bit anywhere.
          result_d = FULL_CNT;
          state_d  = DONE;
        end else begin
          cnt_d  = cnt_q + NIB_STEP;
          scan_d = scan_q << NIB_W;
        end
        if (state_d == DONE) begin
          zero_d  = (result_d == '0);
          carry_d = (result_d == FULL_CNT);
        end
      end
      DONE: begin
        // start is deliberately not sampled here.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs; reset covers control and visible result,
  // scan/count are working data only valid after a capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
    scan_q <= scan_d;
    cnt_q  <= cnt_d;
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.Result   = zext_cnt(result_q);
  assign bus.Zero     = zero_q;
  assign bus.Carry    = carry_q;
  assign bus.Negative = 1'b0;
  assign bus.Overflow = 1'b0;

endmodule
